seg7_counter_ctrl: RTL



---
 rtl/seg7_counter_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/seg7_counter_ctrl.sv
// Push-button up/down digit counter with synchronised, debounced buttons,
// decimal/hex wrap and a 7-segment encoder with a blinking decimal point.
module seg7_counter_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned BLINK_CYCLES    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_clr,
    input  logic       hex_mode,
    output logic [7:0] segments,
    output logic [3:0] digit,
    output logic [2:0] press
);

    localparam int unsigned NB    = 3;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned BLK_W = $clog2(BLINK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_CYCLES - 1);

    logic [NB-1:0]             w_btn;
    logic [NB-1:0]             r_sync1;
    logic [NB-1:0]             r_sync2;
    logic [NB-1:0]             r_lvl;
    logic [NB-1:0]             r_lvl_d;
    logic [NB-1:0][CNT_W-1:0]  r_cnt;
    logic [NB-1:0]             r_press;
    logic [3:0]                r_digit;
    logic [3:0]                w_digit_nxt;
    logic [3:0]                w_max;
    logic [BLK_W-1:0]          r_blink_cnt;
    logic                      r_dp;
    logic [6:0]                w_seg7;

    assign w_btn = {btn_clr, btn_down, btn_up};

    // Two-flop synchroniser for the asynchronous buttons
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Per-button debouncer: level flips only after DEBOUNCE_CYCLES of disagreement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lvl <= '0;
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (r_sync2[i] == r_lvl[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_lvl[i] <= ~r_lvl[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Rising-edge detect on debounced levels gives one pulse per press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lvl_d <= '0;
            r_press <= '0;
        end else begin
            r_lvl_d <= r_lvl;
            r_press <= r_lvl & ~r_lvl_d;
        end
    end

    assign w_max = hex_mode ? 4'hF : 4'h9;

    // Clear and out-of-range force win over up/down; simultaneous up+down cancels
    always_comb begin
        w_digit_nxt = r_digit;
        if (ena) begin
            if (r_press[2] || (!hex_mode && (r_digit > 4'd9))) begin
                w_digit_nxt = 4'd0;
            end else if (r_press[0] && !r_press[1]) begin
                w_digit_nxt = (r_digit == w_max) ? 4'd0 : r_digit + 4'd1;
            end else if (r_press[1] && !r_press[0]) begin
                w_digit_nxt = (r_digit == 4'd0) ? w_max : r_digit - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit <= '0;
        end else begin
            r_digit <= w_digit_nxt;
        end
    end

    // Heartbeat: decimal point toggles each time the blink counter wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_dp        <= 1'b0;
        end else if (r_blink_cnt == BLK_MAX) begin
            r_blink_cnt <= '0;
            r_dp        <= ~r_dp;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLK_W'(1);
        end
    end

    always_comb begin
        w_seg7 = 7'h00;
        case (r_digit)
            4'h0: w_seg7 = 7'h3F;
            4'h1: w_seg7 = 7'h06;
            4'h2: w_seg7 = 7'h5B;
            4'h3: w_seg7 = 7'h4F;
            4'h4: w_seg7 = 7'h66;
            4'h5: w_seg7 = 7'h6D;
            4'h6: w_seg7 = 7'h7D;
            4'h7: w_seg7 = 7'h07;
            4'h8: w_seg7 = 7'h7F;
            4'h9: w_seg7 = 7'h6F;
            4'hA: w_seg7 = 7'h77;
            4'hB: w_seg7 = 7'h7C;
            4'hC: w_seg7 = 7'h39;
            4'hD: w_seg7 = 7'h5E;
            4'hE: w_seg7 = 7'h79;
            4'hF: w_seg7 = 7'h71;
            default: w_seg7 = 7'h00;
        endcase
    end

    assign segments = ena ? {r_dp, w_seg7} : 8'h00;
    assign digit    = r_digit;
    assign press    = r_press;

endmodule
